// File: rtl/buffer_ctrl.sv
// buffer_ctrl
//   Sequencing and arbitration controller for the packet data buffer.
//   Tracks which side owns the buffer (USB RX, host read-out, host TX fill,
//   USB TX) and issues the buffer store/get/clear/flush strobes. Requests that
//   would over- or under-run the buffer, or that arrive in the wrong state, are
//   refused with host_err and never reach the buffer.
//
// Ports
//   clk, n_rst        clock, asynchronous active-low reset
//   buffer_occ        current buffer occupancy (bytes)
//   host_write/read   host access requests, host_size selects 1/2/4 bytes
//   host_clear        software clear, highest priority
//   host_ack/err      per-cycle accept/refuse of a host request
//   rx_*              USB RX engine events
//   tx_*              USB TX engine events
//   store_rx_data     1-byte RX store strobe
//   get_rx_data       host RX read strobe (1=1B, 2=2B, 3=4B)
//   store_tx_data     host TX write strobe (same encoding)
//   get_tx_data       1-byte TX read strobe
//   clear, flush      buffer clear / flush strobes
//   rx_data_ready     level: received packet waiting for the host
//   tx_empty          level: sending and the buffer has run dry
//   overflow          sticky: an RX byte was dropped on a full buffer
//   pkt_len           bytes stored in the current/last RX packet
//
// Strobes, host_ack and host_err are Mealy outputs of the registered state and
// the current inputs; they are forced to zero while n_rst is low.
module buffer_ctrl #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [$clog2(DEPTH):0]   buffer_occ,
  input  logic                     host_write,
  input  logic                     host_read,
  input  logic [1:0]               host_size,
  input  logic                     host_clear,
  output logic                     host_ack,
  output logic                     host_err,
  input  logic                     rx_start,
  input  logic                     rx_byte_valid,
  input  logic                     rx_done,
  input  logic                     rx_abort,
  input  logic                     tx_start,
  input  logic                     tx_byte_req,
  input  logic                     tx_done,
  output logic                     store_rx_data,
  output logic [1:0]               get_rx_data,
  output logic [1:0]               store_tx_data,
  output logic                     get_tx_data,
  output logic                     clear,
  output logic                     flush,
  output logic                     rx_data_ready,
  output logic                     tx_empty,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   pkt_len
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  typedef logic [OCC_W-1:0] occ_t;
  // One extra bit so occupancy + access size cannot wrap.
  typedef logic [OCC_W:0]   sum_t;

  typedef enum logic [2:0] {
    IDLE,
    RX_ACTIVE,
    RX_READY,
    TX_FILL,
    TX_SEND
  } state_t;

  state_t state;
  state_t state_nxt;

  logic   ovf_set;
  logic   len_inc;
  logic   stats_clr;

  sum_t   req_n;
  logic [1:0] req_code;
  logic   wr_fits;
  logic   rd_fits;
  logic   occ_full;
  logic   occ_empty;

  // Access size decode: bytes moved and the matching strobe code.
  always_comb begin
    req_n    = sum_t'(4);
    req_code = 2'd3;
    case (host_size)
      2'd0: begin
        req_n    = sum_t'(1);
        req_code = 2'd1;
      end
      2'd1: begin
        req_n    = sum_t'(2);
        req_code = 2'd2;
      end
      default: begin
        req_n    = sum_t'(4);
        req_code = 2'd3;
      end
    endcase
  end

  assign wr_fits   = (sum_t'(buffer_occ) + req_n) <= sum_t'(DEPTH);
  assign rd_fits   = sum_t'(buffer_occ) >= req_n;
  assign occ_full  = buffer_occ >= occ_t'(DEPTH);
  assign occ_empty = (buffer_occ == '0);

  // Request arbitration and strobe generation.
  always_comb begin
    state_nxt     = state;
    host_ack      = 1'b0;
    host_err      = 1'b0;
    store_rx_data = 1'b0;
    get_rx_data   = '0;
    store_tx_data = '0;
    get_tx_data   = 1'b0;
    clear         = 1'b0;
    flush         = 1'b0;
    ovf_set       = 1'b0;
    len_inc       = 1'b0;
    stats_clr     = 1'b0;

    if (!n_rst) begin
      state_nxt = IDLE;
    end else if (host_clear) begin
      clear     = 1'b1;
      stats_clr = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rx_start) begin
            clear     = 1'b1;
            stats_clr = 1'b1;
            state_nxt = RX_ACTIVE;
            host_err  = host_write | host_read;
          end else if (host_write) begin
            // The first write of a TX fill is served in the same cycle.
            state_nxt = TX_FILL;
            if (wr_fits) begin
              store_tx_data = req_code;
              host_ack      = 1'b1;
            end else begin
              host_err = 1'b1;
            end
          end else if (host_read) begin
            host_err = 1'b1;
          end
        end

        RX_ACTIVE: begin
          host_err = host_write | host_read;
          if (rx_abort) begin
            flush     = 1'b1;
            state_nxt = IDLE;
          end else begin
            if (rx_byte_valid) begin
              if (!occ_full) begin
                store_rx_data = 1'b1;
                len_inc       = 1'b1;
              end else begin
                ovf_set = 1'b1;
              end
            end
            if (rx_done) begin
              state_nxt = RX_READY;
            end
          end
        end

        RX_READY: begin
          if (host_write) begin
            host_err = 1'b1;
          end else if (host_read) begin
            if (rd_fits) begin
              get_rx_data = req_code;
              host_ack    = 1'b1;
            end else begin
              host_err = 1'b1;
            end
          end
          if (!host_read && occ_empty) begin
            state_nxt = IDLE;
          end
        end

        TX_FILL: begin
          if (tx_start) begin
            state_nxt = TX_SEND;
            host_err  = host_write | host_read;
          end else if (host_write) begin
            if (wr_fits) begin
              store_tx_data = req_code;
              host_ack      = 1'b1;
            end else begin
              host_err = 1'b1;
            end
          end else if (host_read) begin
            host_err = 1'b1;
          end
        end

        TX_SEND: begin
          host_err = host_write | host_read;
          if (tx_done) begin
            flush     = 1'b1;
            state_nxt = IDLE;
          end else if (tx_byte_req && !occ_empty) begin
            get_tx_data = 1'b1;
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      overflow <= 1'b0;
      pkt_len  <= '0;
    end else begin
      state <= state_nxt;
      if (stats_clr) begin
        overflow <= 1'b0;
        pkt_len  <= '0;
      end else begin
        if (ovf_set) begin
          overflow <= 1'b1;
        end
        if (len_inc) begin
          pkt_len <= pkt_len + 1'b1;
        end
      end
    end
  end

  assign rx_data_ready = (state == RX_READY);
  assign tx_empty      = (state == TX_SEND) && occ_empty;

endmodule

// File: tb/tb_buffer_ctrl.sv
// Self-checking bench for buffer_ctrl. The bench also plays the data buffer:
// occupancy is advanced from the reference model's own expected strobes.
module tb_buffer_ctrl;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [6:0] buffer_occ;
  logic       host_write, host_read, host_clear;
  logic [1:0] host_size;
  logic       host_ack, host_err;
  logic       rx_start, rx_byte_valid, rx_done, rx_abort;
  logic       tx_start, tx_byte_req, tx_done;
  logic       store_rx_data, get_tx_data, clear, flush;
  logic [1:0] get_rx_data, store_tx_data;
  logic       rx_data_ready, tx_empty, overflow;
  logic [6:0] pkt_len;

  buffer_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .buffer_occ(buffer_occ),
    .host_write(host_write), .host_read(host_read), .host_size(host_size),
    .host_clear(host_clear), .host_ack(host_ack), .host_err(host_err),
    .rx_start(rx_start), .rx_byte_valid(rx_byte_valid), .rx_done(rx_done),
    .rx_abort(rx_abort), .tx_start(tx_start), .tx_byte_req(tx_byte_req),
    .tx_done(tx_done), .store_rx_data(store_rx_data), .get_rx_data(get_rx_data),
    .store_tx_data(store_tx_data), .get_tx_data(get_tx_data), .clear(clear),
    .flush(flush), .rx_data_ready(rx_data_ready), .tx_empty(tx_empty),
    .overflow(overflow), .pkt_len(pkt_len)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: ownership phase, buffer fill level, packet statistics.
  typedef enum {M_IDLE, M_RXA, M_RXR, M_TXF, M_TXS} mphase_t;
  mphase_t m_ph, nx_ph;
  int      m_occ, nx_occ, m_len, nx_len;
  bit      m_ovf, nx_ovf;

  int cnt_clear, cnt_srx, cnt_gtx, cnt_ack;
  int grx_q[$];
  logic [19:0] snap;

  function automatic logic [19:0] actual();
    return {host_ack, host_err, store_rx_data, get_rx_data, store_tx_data,
            get_tx_data, clear, flush, rx_data_ready, tx_empty, overflow, pkt_len};
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval(output logic [19:0] ex);
    int n;
    logic [1:0] code, grx, stx;
    logic ack, err, srx, gtx, clr, fl;
    n    = nbytes(host_size);
    code = (n == 1) ? 2'd1 : (n == 2) ? 2'd2 : 2'd3;
    {ack, err, srx, gtx, clr, fl} = '0;
    grx = '0;
    stx = '0;
    nx_ph  = m_ph;
    nx_len = m_len;
    nx_ovf = m_ovf;
    if (host_clear) begin
      clr = 1; nx_ph = M_IDLE; nx_len = 0; nx_ovf = 0;
    end else begin
      case (m_ph)
        M_IDLE: begin
          if (rx_start) begin
            clr = 1; nx_len = 0; nx_ovf = 0; nx_ph = M_RXA;
            err = host_write || host_read;
          end else if (host_write) begin
            nx_ph = M_TXF;
            if (m_occ + n <= DEPTH) begin ack = 1; stx = code; end else err = 1;
          end else if (host_read) err = 1;
        end
        M_RXA: begin
          err = host_write || host_read;
          if (rx_abort) begin
            fl = 1; nx_ph = M_IDLE;
          end else begin
            if (rx_byte_valid) begin
              if (m_occ < DEPTH) begin srx = 1; nx_len = (m_len + 1) % 128; end
              else nx_ovf = 1;
            end
            if (rx_done) nx_ph = M_RXR;
          end
        end
        M_RXR: begin
          if (host_write) err = 1;
          else if (host_read) begin
            if (m_occ >= n) begin ack = 1; grx = code; end else err = 1;
          end
          if (!host_read && m_occ == 0) nx_ph = M_IDLE;
        end
        M_TXF: begin
          if (tx_start) begin
            nx_ph = M_TXS; err = host_write || host_read;
          end else if (host_write) begin
            if (m_occ + n <= DEPTH) begin ack = 1; stx = code; end else err = 1;
          end else if (host_read) err = 1;
        end
        default: begin
          err = host_write || host_read;
          if (tx_done) begin fl = 1; nx_ph = M_IDLE; end
          else if (tx_byte_req && m_occ > 0) gtx = 1;
        end
      endcase
    end
    if (clr || fl) nx_occ = 0;
    else nx_occ = m_occ + int'(srx) - int'(gtx) + ((stx != 0) ? n : 0) - ((grx != 0) ? n : 0);
    ex = {ack, err, srx, grx, stx, gtx, clr, fl, (m_ph == M_RXR),
          (m_ph == M_TXS && m_occ == 0), m_ovf, 7'(m_len)};
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [1:0] sz, input bit clr,
                       input bit rxs, input bit rxv, input bit rxd, input bit rxa,
                       input bit txs, input bit txr, input bit txd);
    host_write = wr; host_read = rd; host_size = sz; host_clear = clr;
    rx_start = rxs; rx_byte_valid = rxv; rx_done = rxd; rx_abort = rxa;
    tx_start = txs; tx_byte_req = txr; tx_done = txd;
  endtask

  task automatic idle_in();
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_occ = 0; m_len = 0; m_ovf = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input string nm);
    logic [19:0] ex;
    buffer_occ = 7'(m_occ);
    #1;
    model_eval(ex);
    snap = actual();
    check(nm, snap, ex);
    cnt_clear += int'(clear);
    cnt_srx   += int'(store_rx_data);
    cnt_gtx   += int'(get_tx_data);
    cnt_ack   += int'(host_ack);
    if (get_rx_data != 2'd0) grx_q.push_back(int'(get_rx_data));
    @(posedge clk);
    m_ph = nx_ph; m_occ = nx_occ; m_len = nx_len; m_ovf = nx_ovf;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    buffer_occ = '0;
    cnt_clear = 0; cnt_srx = 0; cnt_gtx = 0; cnt_ack = 0;
    grx_q.delete();
  endtask

  // Single-cycle response table, applied from the reset (IDLE) state.
  typedef struct {
    bit         rst;
    logic [6:0] occ;
    bit         wr, rd;
    logic [1:0] sz;
    bit         clr, rxs;
    logic [9:0] exp;   // {ack, err, srx, grx[1:0], stx[1:0], gtx, clear, flush}
  } vec_t;
  vec_t vecs[10];

  initial begin
    n_rst = 1'b0;
    buffer_occ = '0;
    idle_in();
    model_reset();
    cnt_clear = 0; cnt_srx = 0; cnt_gtx = 0; cnt_ack = 0;
    snap = '0;

    vecs[0] = '{0, 7'd0,  0, 1, 2'd0, 0, 0, 10'h100};  // read in IDLE refused
    vecs[1] = '{0, 7'd0,  0, 0, 2'd0, 0, 1, 10'h002};  // rx_start clears
    vecs[2] = '{0, 7'd0,  1, 0, 2'd0, 0, 0, 10'h208};  // byte write accepted
    vecs[3] = '{0, 7'd62, 1, 0, 2'd3, 0, 0, 10'h100};  // word would overrun
    vecs[4] = '{0, 7'd62, 1, 0, 2'd1, 0, 0, 10'h210};  // half exactly fills
    vecs[5] = '{0, 7'd60, 1, 0, 2'd2, 0, 0, 10'h218};  // word exactly fills
    vecs[6] = '{0, 7'd64, 1, 0, 2'd0, 0, 0, 10'h100};  // full buffer
    vecs[7] = '{0, 7'd0,  1, 0, 2'd0, 1, 0, 10'h002};  // clear beats write
    vecs[8] = '{1, 7'd0,  1, 0, 2'd0, 0, 1, 10'h000};  // silent in reset
    vecs[9] = '{0, 7'd5,  0, 0, 2'd0, 0, 0, 10'h000};  // nothing requested

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      do_reset();
      if (vecs[i].rst) n_rst = 1'b0;
      drive(vecs[i].wr, vecs[i].rd, vecs[i].sz, vecs[i].clr, vecs[i].rxs, 0, 0, 0, 0, 0, 0);
      buffer_occ = vecs[i].occ;
      #1;
      check($sformatf("vec%0d", i), 32'(actual() >> 10), 32'(vecs[i].exp));
    end

    // RX packet and drain
    do_reset();
    drive(0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0); cyc("rx_start");
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0); cyc("rx_byte");
    end
    drive(0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0); cyc("rx_done");
    check("rx_pkt_len", 32'(pkt_len), 32'd7);
    check("rx_ready", 32'(rx_data_ready), 32'd1);
    drive(0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0); cyc("rd4");
    drive(0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0); cyc("rd2");
    drive(0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("rd1");
    idle_in(); cyc("rx_drained");
    check("rx_back_idle", 32'(rx_data_ready), 32'd0);
    check("rx_clear_cnt", 32'(cnt_clear), 32'd1);
    check("rx_store_cnt", 32'(cnt_srx), 32'd7);
    check("rx_ack_cnt", 32'(cnt_ack), 32'd3);
    check("rx_get_cnt", 32'(grx_q.size()), 32'd3);
    if (grx_q.size() == 3)
      check("rx_get_codes", 32'({grx_q[0][1:0], grx_q[1][1:0], grx_q[2][1:0]}), 32'b11_10_01);

    // RX overflow
    do_reset();
    drive(0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0); cyc("ovf_start");
    for (int i = 0; i < 65; i++) begin
      drive(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0); cyc("ovf_byte");
    end
    check("ovf_store_cnt", 32'(cnt_srx), 32'd64);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_pkt_len", 32'(pkt_len), 32'd64);
    drive(0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0); cyc("ovf_done");
    drive(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("ovf_clear");
    check("ovf_cleared", 32'({overflow, pkt_len}), 32'd0);

    // Under-read
    do_reset();
    drive(0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0); cyc("ur_start");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0); cyc("ur_byte");
    end
    drive(0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0); cyc("ur_done");
    drive(0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0); cyc("ur_read4");
    check("ur_err_nostrobe", 32'({snap[19:18], snap[16:15]}), 32'b0100);

    // TX fill limit and send
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0); cyc("tx_wr4");
    end
    drive(1, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0); cyc("tx_wr2");
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("tx_wr1_63");
    check("tx_63_ack", 32'(snap[19:18]), 32'b10);
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("tx_wr1_64");
    check("tx_64_ack", 32'(snap[19:18]), 32'b10);
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("tx_wr1_full");
    check("tx_full_err", 32'({snap[19:18], snap[14:13]}), 32'b0100);
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("tx_start");
    for (int i = 0; i < 64; i++) begin
      drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("tx_req");
    end
    check("tx_get_cnt", 32'(cnt_gtx), 32'd64);
    buffer_occ = 7'(m_occ);
    #1;
    check("tx_empty", 32'(tx_empty), 32'd1);
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("tx_req_empty");
    check("tx_req_empty_nostrobe", 32'(snap[12]), 32'd0);
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1); cyc("tx_done");
    check("tx_done_flush", 32'(snap[10]), 32'd1);

    // Abort and clear
    do_reset();
    drive(0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0); cyc("ab_start");
    drive(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0); cyc("ab_byte");
    drive(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0); cyc("ab_byte");
    drive(0, 0, 2'd0, 0, 0, 1, 1, 1, 0, 0, 0); cyc("ab_abort");
    check("ab_flush_only", 32'(snap[19:10]), 32'h001);
    drive(0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("ab_idle_read");
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("cl_fill");
    drive(1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("cl_clear_wr");
    check("cl_clear_only", 32'(snap[19:10]), 32'h002);
    drive(0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("cl_idle_read");

    // Mid-packet reset in TX_SEND
    do_reset();
    drive(1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0); cyc("mr_wr");
    drive(1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0); cyc("mr_wr");
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("mr_start");
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("mr_req");
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_rst = 1'b0;
    #1;
    check("mr_outputs_in_reset", 32'(actual()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("mr_after_req");
    drive(0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("mr_after_read");

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
              2'($urandom_range(0, 3)), $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < 3);
        cyc("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
